// File: rtl/sync_estimate_filter.sv
// sync_estimate_filter
//   Captures the final theta/eps result of each 256-sample block from the CP argmax stage.
//   A SEARCH/LOCKED state machine checks that the timing index is consistent from block to
//   block. While LOCKED, the eps values of agreeing blocks are averaged over 2^LOG2_AVG
//   blocks. The results drive the symbol aligner and the CFO corrector.
// Ports
//   clk        clock
//   rst        synchronous, active-high reset (shared with the argmax stage)
//   theta_in   argmax timing index, registered upstream
//   eps_in     Q1.20 signed CFO estimate, registered upstream
//   theta_est  timing index captured at lock
//   eps_est    averaged CFO, Q1.20 signed
//   est_valid  single-cycle pulse when a new eps_est is available
//   locked     high while in the LOCKED state
module sync_estimate_filter #(
    parameter int CNT_INIT   = -283,
    parameter int BLK_LEN    = 256,
    parameter int LOG2_AVG   = 2,
    parameter int THETA_TOL  = 2,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int EPS_W      = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       theta_in,
    input  logic [EPS_W-1:0] eps_in,
    output logic [7:0]       theta_est,
    output logic [EPS_W-1:0] eps_est,
    output logic             est_valid,
    output logic             locked
);

    localparam int AccW  = EPS_W + LOG2_AVG;
    localparam int AvgW  = LOG2_AVG + 1;
    localparam int AgrW  = $clog2(LOCK_CNT + 1);
    localparam int MissW = $clog2(UNLOCK_CNT + 1);

    localparam logic signed [9:0]  CntInit = 10'(CNT_INIT);
    localparam logic signed [10:0] BlkLen  = 11'(BLK_LEN);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e                 state_q, state_d;
    logic signed [9:0]      cnt_q, cnt_d;
    logic                   primed_q, primed_d;
    logic [7:0]             theta_ref_q, theta_ref_d;
    logic [AgrW-1:0]        agree_q, agree_d;
    logic [MissW-1:0]       miss_q, miss_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [AvgW-1:0]        avg_cnt_q, avg_cnt_d;
    logic [7:0]             theta_est_q, theta_est_d;
    logic [EPS_W-1:0]       eps_est_q, eps_est_d;
    logic                   est_valid_q, est_valid_d;
    logic                   locked_q, locked_d;

    logic signed [10:0]     cnt_inc;
    logic                   sample;
    logic signed [7:0]      diff;
    logic                   hit;
    logic signed [AccW-1:0] eps_ext;
    logic signed [AccW-1:0] acc_sum;

    // Mirrors the argmax stage block counter; sample marks the cycle holding a final result.
    assign cnt_inc = {cnt_q[9], cnt_q} + 11'sd1;
    assign sample  = primed_q && (cnt_q == 10'sd0);

    // Circular difference mod 256; -128 falls outside any sane tolerance.
    assign diff    = theta_in - theta_ref_q;
    assign hit     = (int'(diff) >= -THETA_TOL) && (int'(diff) <= THETA_TOL);

    assign eps_ext = AccW'($signed(eps_in));
    assign acc_sum = acc_q + eps_ext;

    always_comb begin
        state_d     = state_q;
        primed_d    = primed_q;
        theta_ref_d = theta_ref_q;
        agree_d     = agree_q;
        miss_d      = miss_q;
        acc_d       = acc_q;
        avg_cnt_d   = avg_cnt_q;
        theta_est_d = theta_est_q;
        eps_est_d   = eps_est_q;
        est_valid_d = 1'b0;
        locked_d    = locked_q;

        if (cnt_inc >= BlkLen) begin
            cnt_d    = 10'sd0;
            primed_d = 1'b1;
        end else begin
            cnt_d = 10'(cnt_inc);
        end

        if (sample) begin
            case (state_q)
                StSearch: begin
                    // agree_q == 0 only for the first sample after reset.
                    if (agree_q != '0 && hit) begin
                        if (agree_q == AgrW'(LOCK_CNT - 1)) begin
                            state_d     = StLocked;
                            locked_d    = 1'b1;
                            theta_est_d = theta_in;
                            agree_d     = '0;
                            miss_d      = '0;
                            acc_d       = '0;
                            avg_cnt_d   = '0;
                        end else begin
                            agree_d = agree_q + AgrW'(1);
                        end
                    end else begin
                        theta_ref_d = theta_in;
                        agree_d     = AgrW'(1);
                    end
                end
                StLocked: begin
                    if (hit) begin
                        miss_d = '0;
                        if (avg_cnt_q == AvgW'((1 << LOG2_AVG) - 1)) begin
                            // Arithmetic shift floors; no rounding by design.
                            eps_est_d   = EPS_W'(acc_sum >>> LOG2_AVG);
                            est_valid_d = 1'b1;
                            acc_d       = '0;
                            avg_cnt_d   = '0;
                        end else begin
                            acc_d     = acc_sum;
                            avg_cnt_d = avg_cnt_q + AvgW'(1);
                        end
                    end else if (miss_q == MissW'(UNLOCK_CNT - 1)) begin
                        // theta_est/eps_est deliberately hold across unlock.
                        state_d     = StSearch;
                        locked_d    = 1'b0;
                        theta_ref_d = theta_in;
                        agree_d     = AgrW'(1);
                        miss_d      = '0;
                        acc_d       = '0;
                        avg_cnt_d   = '0;
                    end else begin
                        miss_d = miss_q + MissW'(1);
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            cnt_q       <= CntInit;
            primed_q    <= 1'b0;
            theta_ref_q <= '0;
            agree_q     <= '0;
            miss_q      <= '0;
            acc_q       <= '0;
            avg_cnt_q   <= '0;
            theta_est_q <= '0;
            eps_est_q   <= '0;
            est_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            theta_ref_q <= theta_ref_d;
            agree_q     <= agree_d;
            miss_q      <= miss_d;
            acc_q       <= acc_d;
            avg_cnt_q   <= avg_cnt_d;
            theta_est_q <= theta_est_d;
            eps_est_q   <= eps_est_d;
            est_valid_q <= est_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign theta_est = theta_est_q;
    assign eps_est   = eps_est_q;
    assign est_valid = est_valid_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_sync_estimate_filter.sv
// Testbench for sync_estimate_filter: directed block-by-block stimulus; expected averages
// are queued when the samples are driven and compared whenever est_valid pulses.
module tb_sync_estimate_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  theta_in = 8'h00;
    logic [20:0] eps_in = '0;
    logic [7:0]  theta_est;
    logic [20:0] eps_est;
    logic        est_valid;
    logic        locked;

    int          checks = 0;
    int          errors = 0;
    int          wait_edges = 540;
    logic        prev_locked = 1'b0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    sync_estimate_filter dut (
        .clk       (clk),
        .rst       (rst),
        .theta_in  (theta_in),
        .eps_in    (eps_in),
        .theta_est (theta_est),
        .eps_est   (eps_est),
        .est_valid (est_valid),
        .locked    (locked)
    );

    function automatic logic [31:0] sx(input logic [20:0] v);
        return {{11{v[20]}}, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every est_valid pulse must match the oldest queued average.
    always @(negedge clk) begin
        if (est_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_est_valid", 32'd1, 32'd0);
            else check("eps_est", sx(eps_est), sx(exp_q.pop_front()));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_theta_est", {24'd0, theta_est}, 32'd0);
        check("rst_eps_est", sx(eps_est), 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_est_valid", {31'd0, est_valid}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        prev_locked = 1'b0;
        wait_edges  = 540;
    endtask

    // Hold one block's inputs across the next sample edge and check the outputs around it.
    task automatic step(input logic [7:0] th, input int eps, input logic exp_lock,
                        input logic [7:0] exp_th, input logic exp_v);
        theta_in = th;
        eps_in   = 21'(eps);
        repeat (wait_edges - 1) @(posedge clk);
        #1;
        check("pre_edge_locked", {31'd0, locked}, {31'd0, prev_locked});
        check("pre_edge_est_valid", {31'd0, est_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("locked", {31'd0, locked}, {31'd0, exp_lock});
        check("theta_est", {24'd0, theta_est}, {24'd0, exp_th});
        check("est_valid", {31'd0, est_valid}, {31'd0, exp_v});
        @(posedge clk);
        #1;
        check("est_valid_width", {31'd0, est_valid}, 32'd0);
        prev_locked = exp_lock;
        wait_edges  = 255;
    endtask

    initial begin
        do_reset();

        // Acquire lock at 0x40 on the third sample.
        step(8'h40, 0, 1'b0, 8'h00, 1'b0);
        step(8'h40, 0, 1'b0, 8'h00, 1'b0);
        step(8'h40, 0, 1'b1, 8'h40, 1'b0);

        // Four-sample averages, positive and negative (floor).
        exp_q.push_back(21'(250));
        step(8'h40, 100, 1'b1, 8'h40, 1'b0);
        step(8'h40, 200, 1'b1, 8'h40, 1'b0);
        step(8'h40, 300, 1'b1, 8'h40, 1'b0);
        step(8'h40, 400, 1'b1, 8'h40, 1'b1);
        exp_q.push_back(21'(-2));
        step(8'h40, -1, 1'b1, 8'h40, 1'b0);
        step(8'h40, -1, 1'b1, 8'h40, 1'b0);
        step(8'h40, -1, 1'b1, 8'h40, 1'b0);
        step(8'h40, -2, 1'b1, 8'h40, 1'b1);

        // A single disagreeing sample is excluded from the average.
        exp_q.push_back(21'(25));
        step(8'h40, 10, 1'b1, 8'h40, 1'b0);
        step(8'h80, 1000, 1'b1, 8'h40, 1'b0);
        step(8'h40, 20, 1'b1, 8'h40, 1'b0);
        step(8'h40, 30, 1'b1, 8'h40, 1'b0);
        step(8'h40, 40, 1'b1, 8'h40, 1'b1);

        // Two misses unlock; theta_est holds; relock at 0x50.
        step(8'h50, 0, 1'b1, 8'h40, 1'b0);
        step(8'h50, 0, 1'b0, 8'h40, 1'b0);
        step(8'h50, 0, 1'b0, 8'h40, 1'b0);
        step(8'h50, 0, 1'b1, 8'h50, 1'b0);

        // Unlock again, then lock across the 0xFF/0x00 wrap.
        step(8'h10, 0, 1'b1, 8'h50, 1'b0);
        step(8'h10, 0, 1'b0, 8'h50, 1'b0);
        step(8'hFF, 0, 1'b0, 8'h50, 1'b0);
        step(8'h01, 0, 1'b0, 8'h50, 1'b0);
        step(8'h00, 0, 1'b1, 8'h00, 1'b0);

        // Reference is 0xFF: d=-128 and d=+3 miss, d=+2 and d=-1 agree.
        exp_q.push_back(21'(20));
        step(8'h7F, 1000, 1'b1, 8'h00, 1'b0);
        step(8'h01, 8, 1'b1, 8'h00, 1'b0);
        step(8'h02, 500, 1'b1, 8'h00, 1'b0);
        step(8'h01, 16, 1'b1, 8'h00, 1'b0);
        step(8'h00, 24, 1'b1, 8'h00, 1'b0);
        step(8'hFE, 32, 1'b1, 8'h00, 1'b1);

        // Reset after two averaged samples discards all progress.
        step(8'h00, 100, 1'b1, 8'h00, 1'b0);
        step(8'h00, 200, 1'b1, 8'h00, 1'b0);
        do_reset();
        step(8'h22, 0, 1'b0, 8'h00, 1'b0);
        step(8'h22, 0, 1'b0, 8'h00, 1'b0);
        step(8'h22, 0, 1'b1, 8'h22, 1'b0);
        exp_q.push_back(21'(4));
        step(8'h22, 4, 1'b1, 8'h22, 1'b0);
        step(8'h22, 4, 1'b1, 8'h22, 1'b0);
        step(8'h22, 4, 1'b1, 8'h22, 1'b0);
        step(8'h22, 4, 1'b1, 8'h22, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
